// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EXE->MEM bus, captures the SRAM read
// word (holding it across WB stalls), performs load extraction and forwards to WB/ID.
module mem_stage #(
  parameter int          XLEN   = 32,
  parameter logic [31:0] RST_PC = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ms_flush,
  input  logic            es_to_ms_valid,
  output logic            ms_allowin,
  input  logic [XLEN-1:0] es_pc,
  input  logic [XLEN-1:0] es_alu_result,
  input  logic [4:0]      es_dest,
  input  logic            es_rf_we,
  input  logic            es_res_from_mem,
  input  logic [2:0]      es_mem_op,
  input  logic [XLEN-1:0] data_sram_rdata,
  input  logic            ws_allowin,
  output logic            ms_to_ws_valid,
  output logic [XLEN-1:0] ms_pc,
  output logic [XLEN-1:0] ms_final_result,
  output logic [4:0]      ms_dest,
  output logic            ms_rf_we,
  output logic            ms_fwd_valid,
  output logic [4:0]      ms_fwd_dest,
  output logic [XLEN-1:0] ms_fwd_data
);

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  logic            ms_valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] result_r;
  logic [4:0]      dest_r;
  logic            rf_we_r;
  logic            res_from_mem_r;
  logic [2:0]      mem_op_r;
  logic [XLEN-1:0] rdata_hold_r;
  logic            rdata_held_r;

  logic            ms_ready_go_s;
  logic [XLEN-1:0] raw_rdata_s;
  logic [XLEN-1:0] load_data_s;
  logic [XLEN-1:0] final_s;

  // Pick the addressed byte/halfword out of the word and extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      LD_B:    load_ext = {{24{b[7]}}, b};
      LD_BU:   load_ext = {24'h0, b};
      LD_H:    load_ext = {{16{h[15]}}, h};
      LD_HU:   load_ext = {16'h0, h};
      LD_W:    load_ext = w;
      default: load_ext = w;
    endcase
  endfunction

  assign ms_ready_go_s  = 1'b1;
  assign ms_allowin     = !ms_valid_r || (ms_ready_go_s && ws_allowin);
  assign ms_to_ws_valid = ms_valid_r && ms_ready_go_s && !ms_flush;

  // The SRAM word is only valid in the first MEM cycle, so a stalled load replays the held copy.
  assign raw_rdata_s = rdata_held_r ? rdata_hold_r : data_sram_rdata;
  assign load_data_s = load_ext(mem_op_r, result_r[1:0], raw_rdata_s);
  assign final_s     = res_from_mem_r ? load_data_s : result_r;

  assign ms_pc           = pc_r;
  assign ms_final_result = final_s;
  assign ms_dest         = dest_r;
  assign ms_rf_we        = ms_valid_r && rf_we_r;
  assign ms_fwd_valid    = ms_valid_r && rf_we_r && (dest_r != 5'd0) && !ms_flush;
  assign ms_fwd_dest     = dest_r;
  assign ms_fwd_data     = final_s;

  // Stage state: valid bit, EXE bus latch and stall-time read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_r     <= 1'b0;
      pc_r           <= RST_PC;
      result_r       <= '0;
      dest_r         <= 5'd0;
      rf_we_r        <= 1'b0;
      res_from_mem_r <= 1'b0;
      mem_op_r       <= 3'd0;
      rdata_hold_r   <= '0;
      rdata_held_r   <= 1'b0;
    end else begin
      if (ms_flush) begin
        ms_valid_r <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid_r <= es_to_ms_valid;
      end else begin
        ms_valid_r <= ms_valid_r;
      end

      if (es_to_ms_valid && ms_allowin) begin
        pc_r           <= es_pc;
        result_r       <= es_alu_result;
        dest_r         <= es_dest;
        rf_we_r        <= es_rf_we;
        res_from_mem_r <= es_res_from_mem;
        mem_op_r       <= es_mem_op;
      end

      // ms_allowin low means a valid instruction is blocked by WB.
      if (ms_flush || ms_allowin) begin
        rdata_held_r <= 1'b0;
      end else if (ms_valid_r && res_from_mem_r && !rdata_held_r) begin
        rdata_held_r <= 1'b1;
        rdata_hold_r <= data_sram_rdata;
      end
    end
  end

endmodule
